// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the word-wide datamem interface.
// Takes one load/store at a time from the MEM stage over a valid/ready
// handshake. Byte/halfword loads are extracted and extended here, and
// sub-word stores are done as a read-modify-write of the containing word.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// skip memory entirely and complete with resp_err=1. Without the macro,
// the low address bits below the access size are ignored.
module mem_access_unit #(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic [31:0] Writedata,
  output logic        memread,
  output logic        memwrite,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Value of the read-phase counter in the last memread cycle.
  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 32'd1);

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [1:0]  lane_r;
  logic [1:0]  size_r;
  logic        signed_r;
  logic        write_r;
  logic [15:0] wdata_r;
  logic        trap_s;

  // Pick the addressed byte/half out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b   = 8'h00;
    h   = 16'h0000;
    res = word;
    case (lane)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      2'b00:   res = {{24{sext & b[7]}}, b};
      2'b01:   res = {{16{sext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane(s) of a memory word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: begin
        case (lane)
          2'b00:   res[7:0]   = wd[7:0];
          2'b01:   res[15:8]  = wd[7:0];
          2'b10:   res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) begin
          res[31:16] = wd;
        end else begin
          res[15:0] = wd;
        end
      end
      default: res = word;
    endcase
    return res;
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  // Half needs addr[0]=0, word (and size 11) needs addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] lo);
    logic res;
    case (size)
      2'b00:   res = 1'b0;
      2'b01:   res = lo[0];
      default: res = (lo != 2'b00);
    endcase
    return res;
  endfunction

  assign trap_s = misaligned(req_size, req_addr[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      lane_r     <= 2'b00;
      size_r     <= 2'b00;
      signed_r   <= 1'b0;
      write_r    <= 1'b0;
      wdata_r    <= 16'h0000;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0000_0000;
      resp_err   <= 1'b0;
      address    <= 32'h0000_0000;
      Writedata  <= 32'h0000_0000;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            lane_r    <= req_addr[1:0];
            size_r    <= req_size;
            signed_r  <= req_signed;
            write_r   <= req_write;
            wdata_r   <= req_wdata[15:0];
            cnt_r     <= 3'd0;
            req_ready <= 1'b0;
            address   <= {req_addr[31:2], 2'b00};
            if (trap_s) begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else if (req_write && req_size[1]) begin
              state_r   <= WR;
              Writedata <= req_wdata;
              memwrite  <= 1'b1;
            end else begin
              state_r <= RD_WAIT;
              memread <= 1'b1;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (cnt_r == LAT_LAST) begin
            memread <= 1'b0;
            if (write_r) begin
              state_r   <= WR;
              Writedata <= store_merge(readdata, size_r, lane_r, wdata_r);
              memwrite  <= 1'b1;
            end else begin
              state_r    <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= load_extract(readdata, size_r, lane_r, signed_r);
            end
          end else begin
            cnt_r <= cnt_r + 3'd1;
          end
        end
        WR: begin
          memwrite   <= 1'b0;
          state_r    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0000_0000;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          memread    <= 1'b0;
          memwrite   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word memory.
module tb_mem_access_unit;

  localparam int L = 1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] address;
  logic [31:0] Writedata;
  logic        memread;
  logic        memwrite;
  logic [31:0] readdata;

  int checks = 0;
  int errors = 0;

  // Memory model: 64 words, preload port driven by the bench during reset.
  logic [31:0] mem [0:63];
  logic        pre_we;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;

  assign readdata = mem[address[7:2]];

  always @(posedge clk) begin
    if (memwrite) mem[address[7:2]] <= Writedata;
    else if (pre_we) mem[pre_idx] <= pre_data;
  end

  mem_access_unit #(.MEM_RD_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .Writedata(Writedata),
    .memread(memread), .memwrite(memwrite), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last do_req call.
  int          r_lat, r_rd, r_wr, r_wr_at, r_overlap, r_ready_busy;
  logic [31:0] r_wr_addr, r_wr_data, r_rdata;
  logic        r_err, r_after;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int guard;
    r_lat = -1; r_rd = 0; r_wr = 0; r_wr_at = -1; r_overlap = 0; r_ready_busy = 0;
    r_wr_addr = 32'h0; r_wr_data = 32'h0; r_rdata = 32'h0; r_err = 1'b0; r_after = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      if (i > 1) @(negedge clk);
      if (memread) r_rd++;
      if (memwrite) begin
        r_wr++; r_wr_at = i; r_wr_addr = address; r_wr_data = Writedata;
      end
      if (memread && memwrite) r_overlap++;
      if (req_ready) r_ready_busy++;
      if (resp_valid) begin
        r_lat = i; r_rdata = resp_rdata; r_err = resp_err;
        break;
      end
    end
    @(negedge clk);
    r_after = resp_valid;
  endtask

  task automatic test_reset;
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    pre_we = 1'b1; pre_idx = 6'd4; pre_data = 32'hA1B2_C3D4;
    @(posedge clk);
    #1 pre_idx = 6'd8; pre_data = 32'h0000_0000;
    @(posedge clk);
    #1 pre_we = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if ({resp_valid, resp_err, memread, memwrite} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b exp=0000", {resp_valid, resp_err, memread, memwrite}); end
    checks++; if ({address, Writedata, resp_rdata} !== 96'h0) begin
      errors++; $display("FAIL reset_data got=%h/%h/%h exp=0", address, Writedata, resp_rdata); end
    rst = 1'b1;
  endtask

  task automatic test_load;
    do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_FFC3) begin errors++; $display("FAIL lb_data got=%h exp=ffffffc3", r_rdata); end
    checks++; if (r_lat !== L + 1) begin errors++; $display("FAIL lb_latency got=%0d exp=%0d", r_lat, L + 1); end
    checks++; if (r_wr !== 0 || r_rd !== L) begin errors++; $display("FAIL lb_phases rd=%0d wr=%0d exp rd=%0d wr=0", r_rd, r_wr, L); end
    checks++; if (r_after !== 1'b0 || r_ready_busy !== 0) begin
      errors++; $display("FAIL lb_pulse after=%b busy_ready=%0d exp 0/0", r_after, r_ready_busy); end
    do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    checks++; if (r_rdata !== 32'h0000_A1B2) begin errors++; $display("FAIL lhu_data got=%h exp=0000a1b2", r_rdata); end
    do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    checks++; if (r_rdata !== 32'hFFFF_A1B2) begin errors++; $display("FAIL lh_data got=%h exp=ffffa1b2", r_rdata); end
    do_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'h0000_00D4) begin errors++; $display("FAIL lbu_data got=%h exp=000000d4", r_rdata); end
    do_req(1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'hA1B2_C3D4) begin errors++; $display("FAIL lw_data got=%h exp=a1b2c3d4", r_rdata); end
  endtask

  task automatic test_store_byte;
    do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0055);
    checks++; if (r_rd !== L || r_wr !== 1) begin errors++; $display("FAIL sb_phases rd=%0d wr=%0d exp rd=%0d wr=1", r_rd, r_wr, L); end
    checks++; if (r_wr_data !== 32'h55B2_C3D4 || r_wr_addr !== 32'h10) begin
      errors++; $display("FAIL sb_write data=%h addr=%h exp 55b2c3d4/00000010", r_wr_data, r_wr_addr); end
    checks++; if (r_lat !== L + 2 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL sb_resp lat=%0d rdata=%h exp %0d/0", r_lat, r_rdata, L + 2); end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++; if (r_rdata !== 32'h55B2_C3D4) begin errors++; $display("FAIL sb_readback got=%h exp=55b2c3d4", r_rdata); end
  endtask

  task automatic test_store_word;
    do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF);
    checks++; if (r_rd !== 0 || r_wr !== 1 || r_wr_at !== 1) begin
      errors++; $display("FAIL sw_phases rd=%0d wr=%0d at=%0d exp 0/1/1", r_rd, r_wr, r_wr_at); end
    checks++; if (r_lat !== 2 || r_wr_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_resp lat=%0d data=%h exp 2/deadbeef", r_lat, r_wr_data); end
    do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    checks++; if (r_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_readback got=%h exp=deadbeef", r_rdata); end
    do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF_1234);
    checks++; if (r_wr_data !== 32'h1234_BEEF || r_lat !== L + 2) begin
      errors++; $display("FAIL sh_write data=%h lat=%0d exp 1234beef/%0d", r_wr_data, r_lat, L + 2); end
  endtask

  task automatic test_alignment;
`ifdef MEM_MISALIGN_TRAP_EN
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    checks++; if (r_err !== 1'b1 || r_rdata !== 32'h0) begin
      errors++; $display("FAIL trap_resp err=%b rdata=%h exp 1/0", r_err, r_rdata); end
    checks++; if (r_rd !== 0 || r_wr !== 0 || r_lat !== 1) begin
      errors++; $display("FAIL trap_phases rd=%0d wr=%0d lat=%0d exp 0/0/1", r_rd, r_wr, r_lat); end
`else
    do_req(1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
    checks++; if (r_err !== 1'b0 || r_rdata !== 32'h1234_BEEF) begin
      errors++; $display("FAIL lw_trunc err=%b rdata=%h exp 0/1234beef", r_err, r_rdata); end
    do_req(1'b0, 2'b01, 1'b1, 32'h23, 32'h0);
    checks++; if (r_err !== 1'b0 || r_rdata !== 32'h0000_1234) begin
      errors++; $display("FAIL lh_trunc err=%b rdata=%h exp 0/00001234", r_err, r_rdata); end
`endif
  endtask

  task automatic test_back_to_back;
    int first, second, resp1, resp2, ready_low;
    logic [31:0] data1, data2;
    first = -1; second = -1; resp1 = -1; resp2 = -1; ready_low = 0;
    data1 = 32'h0; data2 = 32'h0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    for (int c = 0; c < 60; c++) begin
      if (resp_valid) begin
        if (resp1 < 0) begin resp1 = c; data1 = resp_rdata; end
        else if (resp2 < 0) begin resp2 = c; data2 = resp_rdata; end
      end
      if (req_ready && req_valid) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end else if (first >= 0 && second < 0 && !req_ready) begin
        ready_low++;
      end
      @(posedge clk);
      #1;
      if (first == c) req_addr = 32'h20;
      if (second == c) req_valid = 1'b0;
      if (resp2 >= 0) break;
      @(negedge clk);
    end
    checks++; if (second - first !== L + 2 || ready_low !== L + 1) begin
      errors++; $display("FAIL b2b_accept gap=%0d ready_low=%0d exp %0d/%0d", second - first, ready_low, L + 2, L + 1); end
    checks++; if (resp1 - first !== L + 1 || resp2 - second !== L + 1) begin
      errors++; $display("FAIL b2b_latency r1=%0d r2=%0d exp %0d", resp1 - first, resp2 - second, L + 1); end
    checks++; if (data1 !== 32'h55B2_C3D4 || data2 !== 32'h1234_BEEF) begin
      errors++; $display("FAIL b2b_data d1=%h d2=%h exp 55b2c3d4/1234beef", data1, data2); end
  endtask

  task automatic test_reset_mid;
    int guard, bad_wr, bad_resp;
    guard = 0; bad_wr = 0; bad_resp = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0000_AAAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++; if (memread !== 1'b1) begin errors++; $display("FAIL rstmid_rdwait memread=%b exp=1", memread); end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if ({memread, memwrite, resp_valid, req_ready} !== 4'b0001 || address !== 32'h0) begin
      errors++; $display("FAIL rstmid_outputs rd/wr/rv/rdy=%b addr=%h exp 0001/0", {memread, memwrite, resp_valid, req_ready}, address); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (memwrite) bad_wr++;
      if (resp_valid) bad_resp++;
    end
    checks++; if (bad_wr !== 0 || bad_resp !== 0) begin
      errors++; $display("FAIL rstmid_after memwrite=%0d resp=%0d exp 0/0", bad_wr, bad_resp); end
    checks++; if (mem[4] !== 32'h55B2_C3D4) begin errors++; $display("FAIL rstmid_mem got=%h exp=55b2c3d4", mem[4]); end
  endtask

  initial begin
    int total_overlap;
    total_overlap = 0;
    test_reset();
    test_load();
    total_overlap += r_overlap;
    test_store_byte();
    total_overlap += r_overlap;
    test_store_word();
    total_overlap += r_overlap;
    test_alignment();
    total_overlap += r_overlap;
    test_back_to_back();
    test_reset_mid();
    checks++; if (total_overlap !== 0) begin errors++; $display("FAIL rd_wr_overlap got=%0d exp=0", total_overlap); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
